// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter and its grant logic; the widths
// match the memory_controller transaction port.
package mem_arbiter_pkg;

   localparam int ADDRESS_LEN = 17;
   localparam int WORD_SIZE   = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } arb_state_e;

   typedef enum logic {
      PORT_IF = 1'b0,
      PORT_D  = 1'b1
   } port_id_e;

   function automatic port_id_e other_port(input port_id_e p);
      return (p == PORT_D) ? PORT_IF : PORT_D;
   endfunction

endpackage

// File: rtl/rr_grant2.sv
// Two-requester grant selection: a lone requester wins; on contention either
// the data port wins outright or the port that did not win last time does.
module rr_grant2
   import mem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  port_id_e   last_grant,
   input  logic       fixed_priority,
   output port_id_e   grant
);

   // Grant selection; req[0] is the fetch port, req[1] the data port.
   always_comb begin
      grant = PORT_D;
      case (req)
         2'b01: grant = PORT_IF;
         2'b10: grant = PORT_D;
         2'b11: begin
            if (fixed_priority) begin
               grant = PORT_D;
            end else begin
               grant = other_port(last_grant);
            end
         end
         default: grant = PORT_D;
      endcase
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter and sequencer sharing the serial-SRAM transaction port between the
// fetch and load/store requesters, with a release gap and a watchdog.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned FIXED_PRIORITY = 0,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   ena,
   input  logic                   if_req,
   input  logic [ADDRESS_LEN-1:0] if_addr,
   output logic                   if_done,
   output logic [WORD_SIZE-1:0]   if_rdata,
   input  logic                   d_req,
   input  logic [ADDRESS_LEN-1:0] d_addr,
   input  logic                   d_we,
   input  logic [WORD_SIZE-1:0]   d_wdata,
   output logic                   d_done,
   output logic [WORD_SIZE-1:0]   d_rdata,
   output logic [ADDRESS_LEN-1:0] mem_address,
   output logic [WORD_SIZE-1:0]   mem_write_value,
   output logic                   mem_write_enable,
   output logic                   mem_request,
   input  logic [WORD_SIZE-1:0]   mem_read_value,
   input  logic                   mem_request_complete,
   output logic                   busy,
   output logic                   timeout_error
);

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 32'd1);

   arb_state_e             state_r, state_s;
   port_id_e               last_grant_r, last_grant_s;
   port_id_e               grant_r, grant_s;
   port_id_e               win_s;
   logic [7:0]             tmo_cnt_r, tmo_cnt_s;
   logic [ADDRESS_LEN-1:0] mem_address_r, mem_address_s;
   logic [WORD_SIZE-1:0]   mem_wval_r, mem_wval_s;
   logic                   mem_we_r, mem_we_s;
   logic                   mem_req_r, mem_req_s;
   logic                   if_done_r, if_done_s;
   logic                   d_done_r, d_done_s;
   logic [WORD_SIZE-1:0]   if_rdata_r, if_rdata_s;
   logic [WORD_SIZE-1:0]   d_rdata_r, d_rdata_s;
   logic                   tmo_err_r, tmo_err_s;

   rr_grant2 u_grant (
      .req            ({d_req, if_req}),
      .last_grant     (last_grant_r),
      .fixed_priority (FIXED_PRIORITY != 32'd0),
      .grant          (win_s)
   );

   // Next-state and next-output computation for the IDLE/BUSY/RELEASE sequencer.
   always_comb begin
      state_s       = state_r;
      last_grant_s  = last_grant_r;
      grant_s       = grant_r;
      tmo_cnt_s     = tmo_cnt_r;
      mem_address_s = mem_address_r;
      mem_wval_s    = mem_wval_r;
      mem_we_s      = mem_we_r;
      mem_req_s     = mem_req_r;
      if_done_s     = 1'b0;
      d_done_s      = 1'b0;
      if_rdata_s    = if_rdata_r;
      d_rdata_s     = d_rdata_r;
      tmo_err_s     = tmo_err_r;
      case (state_r)
         IDLE: begin
            if ((if_req | d_req) == 1'b1) begin
               grant_s      = win_s;
               last_grant_s = win_s;
               tmo_cnt_s    = 8'd0;
               mem_req_s    = 1'b1;
               state_s      = BUSY;
               if (win_s == PORT_D) begin
                  mem_address_s = d_addr;
                  mem_wval_s    = d_wdata;
                  mem_we_s      = d_we;
               end else begin
                  mem_address_s = if_addr;
                  mem_wval_s    = {WORD_SIZE{1'b0}};
                  mem_we_s      = 1'b0;
               end
            end else begin
               state_s = IDLE;
            end
         end
         BUSY: begin
            if (mem_request_complete) begin
               mem_req_s = 1'b0;
               state_s   = RELEASE;
               if (grant_r == PORT_D) begin
                  d_done_s  = 1'b1;
                  d_rdata_s = mem_read_value;
               end else begin
                  if_done_s  = 1'b1;
                  if_rdata_s = mem_read_value;
               end
            end else if (tmo_cnt_r == TMO_LAST) begin
               // Stuck transaction: abandon it without a done pulse.
               tmo_cnt_s = tmo_cnt_r + 8'd1;
               tmo_err_s = 1'b1;
               mem_req_s = 1'b0;
               state_s   = RELEASE;
            end else begin
               tmo_cnt_s = tmo_cnt_r + 8'd1;
            end
         end
         RELEASE: state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State and output registers: synchronous reset, full hold while ena is low.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r       <= IDLE;
         last_grant_r  <= PORT_D;
         grant_r       <= PORT_IF;
         tmo_cnt_r     <= 8'd0;
         mem_address_r <= {ADDRESS_LEN{1'b0}};
         mem_wval_r    <= {WORD_SIZE{1'b0}};
         mem_we_r      <= 1'b0;
         mem_req_r     <= 1'b0;
         if_done_r     <= 1'b0;
         d_done_r      <= 1'b0;
         if_rdata_r    <= {WORD_SIZE{1'b0}};
         d_rdata_r     <= {WORD_SIZE{1'b0}};
         tmo_err_r     <= 1'b0;
      end else if (ena) begin
         state_r       <= state_s;
         last_grant_r  <= last_grant_s;
         grant_r       <= grant_s;
         tmo_cnt_r     <= tmo_cnt_s;
         mem_address_r <= mem_address_s;
         mem_wval_r    <= mem_wval_s;
         mem_we_r      <= mem_we_s;
         mem_req_r     <= mem_req_s;
         if_done_r     <= if_done_s;
         d_done_r      <= d_done_s;
         if_rdata_r    <= if_rdata_s;
         d_rdata_r     <= d_rdata_s;
         tmo_err_r     <= tmo_err_s;
      end
   end

   assign mem_address      = mem_address_r;
   assign mem_write_value  = mem_wval_r;
   assign mem_write_enable = mem_we_r;
   assign mem_request      = mem_req_r;
   assign if_done          = if_done_r;
   assign d_done           = d_done_r;
   assign if_rdata         = if_rdata_r;
   assign d_rdata          = d_rdata_r;
   assign busy             = (state_r == BUSY) || (state_r == RELEASE);
   assign timeout_error    = tmo_err_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance (index 0) and a fixed-priority
// instance (index 1) share requester stimulus, each with its own memory model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst, ena, if_req, d_req, d_we, no_complete;
   logic [16:0] if_addr, d_addr;
   logic [15:0] d_wdata;
   logic        if_done [2];
   logic        d_done [2];
   logic        mem_write_enable [2];
   logic        mem_request [2];
   logic        mem_request_complete [2];
   logic        busy [2];
   logic        timeout_error [2];
   logic [15:0] if_rdata [2];
   logic [15:0] d_rdata [2];
   logic [15:0] mem_write_value [2];
   logic [15:0] mem_read_value [2];
   logic [15:0] rd_next [2];
   logic [16:0] mem_address [2];
   int          mcnt [2];
   int          lat;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   mem_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(10)) dut_rr (
      .clk(clk), .rst(rst), .ena(ena),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done[0]), .if_rdata(if_rdata[0]),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
      .d_done(d_done[0]), .d_rdata(d_rdata[0]),
      .mem_address(mem_address[0]), .mem_write_value(mem_write_value[0]),
      .mem_write_enable(mem_write_enable[0]), .mem_request(mem_request[0]),
      .mem_read_value(mem_read_value[0]), .mem_request_complete(mem_request_complete[0]),
      .busy(busy[0]), .timeout_error(timeout_error[0])
   );

   mem_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(10)) dut_fp (
      .clk(clk), .rst(rst), .ena(ena),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done[1]), .if_rdata(if_rdata[1]),
      .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
      .d_done(d_done[1]), .d_rdata(d_rdata[1]),
      .mem_address(mem_address[1]), .mem_write_value(mem_write_value[1]),
      .mem_write_enable(mem_write_enable[1]), .mem_request(mem_request[1]),
      .mem_read_value(mem_read_value[1]), .mem_request_complete(mem_request_complete[1]),
      .busy(busy[1]), .timeout_error(timeout_error[1])
   );

   // Memory controller model: complete rises 'lat' cycles after mem_request, clears once it drops.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (rst || !mem_request[k]) begin
            mcnt[k] = 0;
            mem_request_complete[k] = 1'b0;
         end else if (!mem_request_complete[k] && !no_complete) begin
            mcnt[k] = mcnt[k] + 1;
            if (mcnt[k] >= lat) begin
               mem_request_complete[k] = 1'b1;
               mem_read_value[k] = rd_next[k];
            end
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1; ena = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = 17'h0; d_addr = 17'h0; d_wdata = 16'h0;
      no_complete = 1'b0; lat = 4;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_done(input int k, output logic got_if, output logic got_d,
                            output int cycles);
      got_if = 1'b0; got_d = 1'b0; cycles = -1;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (if_done[k] || d_done[k]) begin
            got_if = if_done[k]; got_d = d_done[k]; cycles = c + 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      for (int k = 0; k < 2; k++) begin
         n_checks++;
         if ({mem_request[k], busy[k], if_done[k], d_done[k], timeout_error[k],
              mem_write_enable[k]} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl[%0d]: req/busy/ifd/dd/err/we=%b%b%b%b%b%b required 000000", k,
                     mem_request[k], busy[k], if_done[k], d_done[k], timeout_error[k], mem_write_enable[k]);
         end
         n_checks++;
         if ({mem_address[k], mem_write_value[k], if_rdata[k], d_rdata[k]} !== 65'h0) begin
            n_fail++;
            $display("FAIL reset_data[%0d]: addr=%h wval=%h ifr=%h dr=%h required all 0", k,
                     mem_address[k], mem_write_value[k], if_rdata[k], d_rdata[k]);
         end
      end
   endtask

   task automatic test_fetch();
      logic gi, gd; int cyc;
      do_reset();
      rd_next[0] = 16'h3A21; rd_next[1] = 16'h3A21;
      if_addr = 17'h00100; if_req = 1'b1;
      tick();
      n_checks++;
      if ({mem_request[0], mem_address[0], mem_write_enable[0]} !== {1'b1, 17'h00100, 1'b0}) begin
         n_fail++;
         $display("FAIL fetch_issue: req=%b addr=%h we=%b required 1 00100 0",
                  mem_request[0], mem_address[0], mem_write_enable[0]);
      end
      wait_done(0, gi, gd, cyc);
      n_checks++;
      if ({gi, gd, if_rdata[0]} !== {1'b1, 1'b0, 16'h3A21} || cyc != 4) begin
         n_fail++;
         $display("FAIL fetch_done: ifd=%b dd=%b rdata=%h cycles=%0d required 1 0 3a21 4",
                  gi, gd, if_rdata[0], cyc);
      end
      if_req = 1'b0;
      tick();
      n_checks++;
      if ({if_done[0], d_done[0], if_rdata[0]} !== {1'b0, 1'b0, 16'h3A21}) begin
         n_fail++;
         $display("FAIL fetch_pulse: ifd=%b dd=%b rdata=%h required 0 0 3a21",
                  if_done[0], d_done[0], if_rdata[0]);
      end
   endtask

   task automatic test_store();
      logic gi, gd; int cyc;
      do_reset();
      rd_next[0] = 16'h0F0F;
      d_addr = 17'h00200; d_wdata = 16'hBEEF; d_we = 1'b1; d_req = 1'b1;
      tick();
      n_checks++;
      if ({mem_address[0], mem_write_value[0], mem_write_enable[0]} !== {17'h00200, 16'hBEEF, 1'b1}) begin
         n_fail++;
         $display("FAIL store_issue: addr=%h wval=%h we=%b required 00200 beef 1",
                  mem_address[0], mem_write_value[0], mem_write_enable[0]);
      end
      wait_done(0, gi, gd, cyc);
      d_req = 1'b0;
      n_checks++;
      if ({gi, gd, mem_request[0], busy[0]} !== 4'b0101) begin
         n_fail++;
         $display("FAIL store_done: ifd=%b dd=%b req=%b busy=%b required 0 1 0 1",
                  gi, gd, mem_request[0], busy[0]);
      end
      tick();
      n_checks++;
      if ({d_done[0], busy[0], mem_request[0]} !== 3'b000) begin
         n_fail++;
         $display("FAIL store_release: dd=%b busy=%b req=%b required 000",
                  d_done[0], busy[0], mem_request[0]);
      end
   endtask

   task automatic test_contention_rr();
      logic gi, gd; int cyc; int last = 1; int exp_port;
      do_reset();
      if_addr = 17'h01111; d_addr = 17'h02222; d_we = 1'b0; d_wdata = 16'h0;
      if_req = 1'b1; d_req = 1'b1;
      for (int t = 0; t < 4; t++) begin
         rd_next[0] = 16'($urandom);
         exp_port = (last == 1) ? 0 : 1;
         wait_done(0, gi, gd, cyc);
         n_checks++;
         if ({gi, gd} !== ((exp_port == 0) ? 2'b10 : 2'b01) ||
             mem_address[0] !== ((exp_port == 0) ? if_addr : d_addr) ||
             ((exp_port == 0) ? if_rdata[0] : d_rdata[0]) !== rd_next[0]) begin
            n_fail++;
            $display("FAIL rr_grant%0d: ifd=%b dd=%b addr=%h required port %0d data %h",
                     t, gi, gd, mem_address[0], exp_port, rd_next[0]);
         end
         last = exp_port;
      end
      if_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_contention_fp();
      logic gi, gd; int cyc;
      do_reset();
      rd_next[1] = 16'h7777;
      if_addr = 17'h00300; d_addr = 17'h00400; d_we = 1'b0;
      if_req = 1'b1; d_req = 1'b1;
      for (int t = 0; t < 3; t++) begin
         wait_done(1, gi, gd, cyc);
         d_req = 1'b0;
         n_checks++;
         if ({gi, gd} !== 2'b01) begin
            n_fail++;
            $display("FAIL fp_data_wins%0d: ifd=%b dd=%b required 0 1", t, gi, gd);
         end
         tick();
         if (t < 2) begin
            d_req = 1'b1;
         end
      end
      wait_done(1, gi, gd, cyc);
      if_req = 1'b0;
      n_checks++;
      if ({gi, gd, mem_address[1]} !== {2'b10, 17'h00300}) begin
         n_fail++;
         $display("FAIL fp_fetch_last: ifd=%b dd=%b addr=%h required 1 0 00300", gi, gd, mem_address[1]);
      end
   endtask

   task automatic test_timeout();
      logic gi, gd; int cyc; logic any_done = 1'b0;
      do_reset();
      no_complete = 1'b1;
      if_addr = 17'h00500; if_req = 1'b1;
      tick();
      for (int i = 1; i <= 10; i++) begin
         tick();
         any_done = any_done | if_done[0] | d_done[0];
         if (i == 9) begin
            n_checks++;
            if ({timeout_error[0], mem_request[0]} !== 2'b01) begin
               n_fail++;
               $display("FAIL timeout_early: err=%b req=%b required 0 1", timeout_error[0], mem_request[0]);
            end
         end
      end
      n_checks++;
      if ({timeout_error[0], mem_request[0], any_done} !== 3'b100) begin
         n_fail++;
         $display("FAIL timeout_fire: err=%b req=%b done_seen=%b required 1 0 0",
                  timeout_error[0], mem_request[0], any_done);
      end
      no_complete = 1'b0;
      rd_next[0] = 16'h5A5A;
      wait_done(0, gi, gd, cyc);
      if_req = 1'b0;
      n_checks++;
      if ({gi, gd, if_rdata[0], timeout_error[0]} !== {2'b10, 16'h5A5A, 1'b1}) begin
         n_fail++;
         $display("FAIL timeout_recover: ifd=%b dd=%b rdata=%h err=%b required 1 0 5a5a 1",
                  gi, gd, if_rdata[0], timeout_error[0]);
      end
   endtask

   task automatic test_rst_mid();
      logic gi, gd; int cyc; logic any_done = 1'b0;
      do_reset();
      rd_next[0] = 16'h1234;
      if_addr = 17'h00600; if_req = 1'b1;
      tick();
      tick();
      rst = 1'b1; if_req = 1'b0;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({mem_request[0], busy[0], if_done[0], d_done[0]} !== 4'b0000) begin
         n_fail++;
         $display("FAIL rst_mid: req=%b busy=%b ifd=%b dd=%b required 0000",
                  mem_request[0], busy[0], if_done[0], d_done[0]);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         any_done = any_done | if_done[0] | d_done[0] | mem_request[0];
      end
      n_checks++;
      if (any_done !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_lost: activity=%b required 0", any_done);
      end
      rd_next[0] = 16'hC0DE;
      if_req = 1'b1;
      wait_done(0, gi, gd, cyc);
      if_req = 1'b0;
      n_checks++;
      if ({gi, gd, if_rdata[0]} !== {2'b10, 16'hC0DE}) begin
         n_fail++;
         $display("FAIL rst_reissue: ifd=%b dd=%b rdata=%h required 1 0 c0de", gi, gd, if_rdata[0]);
      end
   endtask

   task automatic test_enable();
      logic stray = 1'b0;
      do_reset();
      rd_next[0] = 16'h4242;
      ena = 1'b0; if_addr = 17'h00055; if_req = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         stray = stray | mem_request[0] | busy[0];
      end
      ena = 1'b1;
      tick();
      ena = 1'b0;
      n_checks++;
      if ({stray, mem_request[0]} !== 2'b01) begin
         n_fail++;
         $display("FAIL ena_idle_hold: early=%b req=%b required 0 1", stray, mem_request[0]);
      end
      for (int i = 0; i < 6; i++) begin
         tick();
         stray = stray | if_done[0] | ~mem_request[0];
      end
      ena = 1'b1;
      tick();
      if_req = 1'b0;
      n_checks++;
      if ({stray, if_done[0], if_rdata[0]} !== {2'b01, 16'h4242}) begin
         n_fail++;
         $display("FAIL ena_busy_hold: frozen_bad=%b ifd=%b rdata=%h required 0 1 4242",
                  stray, if_done[0], if_rdata[0]);
      end
   endtask

   task automatic test_random();
      int n_tx = 0; int last = 1; int cur = 0;
      logic [15:0] exp_rd = 16'h0;
      logic [1:0] req_at_edge;
      logic mreq_before;
      logic skip_if = 1'b0, skip_d = 1'b0;
      do_reset();
      for (int cyc = 0; cyc < 4000 && n_tx < 24; cyc++) begin
         if (!if_req && !skip_if && $urandom_range(3) == 0) begin
            if_addr = 17'($urandom); if_req = 1'b1;
         end
         if (!d_req && !skip_d && $urandom_range(3) == 0) begin
            d_addr = 17'($urandom); d_we = 1'($urandom); d_wdata = 16'($urandom); d_req = 1'b1;
         end
         skip_if = 1'b0; skip_d = 1'b0;
         req_at_edge = {d_req, if_req};
         mreq_before = mem_request[0];
         tick();
         if (!mreq_before && mem_request[0]) begin
            if (req_at_edge == 2'b11) cur = (last == 1) ? 0 : 1;
            else if (req_at_edge == 2'b10) cur = 1;
            else cur = 0;
            last = cur;
            n_checks++;
            if ((cur == 1 && {mem_address[0], mem_write_enable[0], mem_write_value[0]} !== {d_addr, d_we, d_wdata}) ||
                (cur == 0 && {mem_address[0], mem_write_enable[0]} !== {if_addr, 1'b0})) begin
               n_fail++;
               $display("FAIL rand_grant%0d: addr=%h we=%b wval=%h expected port %0d", n_tx,
                        mem_address[0], mem_write_enable[0], mem_write_value[0], cur);
            end
            rd_next[0] = 16'($urandom);
            exp_rd = rd_next[0];
         end
         if (if_done[0] || d_done[0]) begin
            n_checks++;
            if ({if_done[0], d_done[0]} !== ((cur == 1) ? 2'b01 : 2'b10) ||
                ((cur == 1) ? d_rdata[0] : if_rdata[0]) !== exp_rd) begin
               n_fail++;
               $display("FAIL rand_done%0d: ifd=%b dd=%b ifr=%h dr=%h required port %0d data %h", n_tx,
                        if_done[0], d_done[0], if_rdata[0], d_rdata[0], cur, exp_rd);
            end
            if (cur == 1) begin
               d_req = 1'b0; skip_d = 1'b1;
            end else begin
               if_req = 1'b0; skip_if = 1'b1;
            end
            n_tx++;
            lat = $urandom_range(6, 2);
         end
      end
      n_checks++;
      if (n_tx < 24) begin
         n_fail++;
         $display("FAIL rand_progress: %0d transactions completed, required 24", n_tx);
      end
      if_req = 1'b0; d_req = 1'b0;
   endtask

   initial begin
      rst = 1'b1; ena = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = 17'h0; d_addr = 17'h0; d_wdata = 16'h0;
      no_complete = 1'b0; lat = 4;
      rd_next[0] = 16'h0; rd_next[1] = 16'h0;
      mem_read_value[0] = 16'h0; mem_read_value[1] = 16'h0;
      mem_request_complete[0] = 1'b0; mem_request_complete[1] = 1'b0;
      mcnt[0] = 0; mcnt[1] = 0;
      test_reset();
      test_fetch();
      test_store();
      test_contention_rr();
      test_contention_fp();
      test_timeout();
      test_rst_mid();
      test_enable();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
